// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared types and defaults for the FIFO read-side stream adapter
package fifo_rd_stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus downstream valid/ready stream
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // master is the adapter; slave is the FIFO plus consumer side
  modport master (
    output fifo_cs, fifo_rd_en, m_valid, m_data,
    input  fifo_empty, fifo_dout, m_ready
  );

  modport slave (
    input  fifo_cs, fifo_rd_en, m_valid, m_data,
    output fifo_empty, fifo_dout, m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry output buffer with push/pop and occupancy state
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output occ_e                  occ_o
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem0_q, mem1_q;
  logic                  head_q, tail_q;
  logic                  do_pop;

  assign do_pop  = pop_i && (occ_q != OCC_EMPTY);
  assign valid_o = (occ_q != OCC_EMPTY);
  assign dout_o  = head_q ? mem1_q : mem0_q;
  assign occ_o   = occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      mem0_q <= '0;
      mem1_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (push_i) begin
        if (tail_q) mem1_q <= din_i;
        else        mem0_q <= din_i;
        tail_q <= ~tail_q;
      end
      if (do_pop) head_q <= ~head_q;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (push_i) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (push_i && !do_pop)      occ_d = OCC_TWO;
        else if (!push_i && do_pop) occ_d = OCC_EMPTY;
      end
      OCC_TWO:   if (!push_i && do_pop) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  // The issue logic never lets a capture land on a full buffer without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !do_pop && occ_q == OCC_TWO));

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO reader that hides read latency and presents a valid/ready stream
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic                 busy_o
);

  occ_e                 occ;
  logic [1:0]           occ_raw;
  logic [1:0]           level;
  logic                 pop;
  logic                 room;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .din_i  (bus.fifo_dout),
    .pop_i  (pop),
    .valid_o(bus.m_valid),
    .dout_o (bus.m_data),
    .occ_o  (occ)
  );

  assign occ_raw = occ;
  assign pop     = bus.m_valid && bus.m_ready;
  assign level   = occ_raw + {1'b0, inflight_q};

  // Space left after this cycle's pop; m_ready feeds this directly so a
  // draining buffer can be refilled in the same cycle.
  assign room = (level < 2'd2) || (pop && (level == 2'd2));

  assign bus.fifo_cs    = en_i;
  assign bus.fifo_rd_en = rst && en_i && !bus.fifo_empty && room;

  assign inflight_d = bus.fifo_rd_en;
  assign rd_count_d = pop ? rd_count_q + CNT_WIDTH'(1) : rd_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count_o = rd_count_q;
  assign busy_o     = (occ != OCC_EMPTY) || inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a behavioural FIFO
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty_v = 1'b1;
  logic [31:0] fifo_dout_v = 32'd0;
  logic [3:0]  rd_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic [31:0] stage_q[$];
  logic [31:0] exp_q[$];
  int          popped = 0;
  int          delivered = 0;
  int          hs_total = 0;
  bit          infl_m = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [31:0] prev_data = 32'd0;

  fifo_rd_stream_if #(.DATA_WIDTH(32)) bus_if ();

  assign bus_if.fifo_empty = fifo_empty_v;
  assign bus_if.fifo_dout  = fifo_dout_v;
  assign bus_if.m_ready    = m_ready;

  fifo_rd_stream #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .bus       (bus_if),
    .rd_count_o(rd_count),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp_v);
    end
  endtask

  // Behavioural FIFO: one-cycle registered read, loads become visible at the next edge.
  always @(posedge clk) begin
    bit p;
    p = bus_if.fifo_rd_en && bus_if.fifo_cs && !bus_if.fifo_empty;
    if (p) begin
      fifo_dout_v <= fq.pop_front();
      popped++;
    end
    infl_m = p;
    while (stage_q.size() > 0) fq.push_back(stage_q.pop_front());
    fifo_empty_v <= (fq.size() == 0);
  end

  // Monitor: words out of the FIFO but not yet delivered are at most two;
  // the newest of them is still in flight if a pop happened at the last edge.
  always @(negedge clk) begin
    int   outst;
    logic hs;
    logic exp_rd;
    if (rst) begin
      outst  = popped - delivered;
      hs     = bus_if.m_valid && bus_if.m_ready;
      exp_rd = en && !bus_if.fifo_empty && ((outst - int'(hs)) < 2);
      check("outstanding_le_2", 32'(outst <= 2), 32'd1);
      check("busy", 32'(busy), 32'((outst != 0)));
      check("m_valid", 32'(bus_if.m_valid), 32'(((outst - int'(infl_m)) != 0)));
      check("fifo_cs", 32'(bus_if.fifo_cs), 32'(en));
      check("fifo_rd_en", 32'(bus_if.fifo_rd_en), 32'(exp_rd));
      check("rd_count", 32'(rd_count), 32'(hs_total % 16));
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(bus_if.m_valid), 32'd1);
        check("hold_data", bus_if.m_data, prev_data);
      end
      if (hs) begin
        if (exp_q.size() == 0) check("unexpected_word", bus_if.m_data, 32'hxxxx_xxxx);
        else                   check("data", bus_if.m_data, exp_q.pop_front());
        delivered++;
        hs_total++;
      end
      prev_valid = bus_if.m_valid;
      prev_ready = bus_if.m_ready;
      prev_data  = bus_if.m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    stage_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic reset_dut(input int cycles);
    int n;
    rst = 1'b0;
    #1;
    check("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(bus_if.fifo_rd_en), 32'd0);
    check("rst_m_data", bus_if.m_data, 32'd0);
    n = popped - delivered;
    repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
    popped     = 0;
    delivered  = 0;
    hs_total   = 0;
    infl_m     = 1'b0;
    prev_valid = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    // Power-up reset with a word waiting in the FIFO
    en = 1'b1;
    m_ready = 1'b1;
    load(32'h1234_5678);
    repeat (3) tick();
    check("por_rd_en", 32'(bus_if.fifo_rd_en), 32'd0);
    check("por_m_valid", 32'(bus_if.m_valid), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    check("por_rd_count", 32'(rd_count), 32'd0);
    check("por_m_data", bus_if.m_data, 32'd0);
    rst = 1'b1;
    repeat (6) tick();

    // Single word latency
    reset_dut(2);
    load(32'hA5A5_0001);
    @(negedge clk);
    @(negedge clk);
    check("sw_rd_en_c0", 32'(bus_if.fifo_rd_en), 32'd1);
    @(negedge clk);
    check("sw_valid_c1", 32'(bus_if.m_valid), 32'd0);
    @(negedge clk);
    check("sw_valid_c2", 32'(bus_if.m_valid), 32'd1);
    check("sw_data_c2", bus_if.m_data, 32'hA5A5_0001);
    @(negedge clk);
    check("sw_valid_c3", 32'(bus_if.m_valid), 32'd0);
    check("sw_count_c3", 32'(rd_count), 32'd1);
    check("sw_busy_c3", 32'(busy), 32'd0);
    tick();

    // Streaming at one word per cycle
    reset_dut(2);
    for (int i = 0; i < 8; i++) load(32'(i));
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("st_rd_en", 32'(bus_if.fifo_rd_en), 32'(c < 8));
      check("st_valid", 32'(bus_if.m_valid), 32'(c >= 2));
      if (c >= 2) check("st_data", bus_if.m_data, 32'(c - 2));
    end
    @(negedge clk);
    check("st_count", 32'(rd_count), 32'd8);
    tick();

    // Backpressure: only two words leave the FIFO
    reset_dut(2);
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(32'(i));
    repeat (12) @(negedge clk);
    check("bp_pops", 32'(popped), 32'd2);
    check("bp_data", bus_if.m_data, 32'd0);
    check("bp_valid", 32'(bus_if.m_valid), 32'd1);
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("bp_drain_valid", 32'(bus_if.m_valid), 32'd1);
      check("bp_drain_data", bus_if.m_data, 32'(c));
    end
    @(negedge clk);
    check("bp_drain_done", 32'(bus_if.m_valid), 32'd0);
    tick();

    // Enable drop mid-stream
    reset_dut(2);
    for (int i = 0; i < 30; i++) load($urandom);
    repeat (6) tick();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("en_drop_rd_en", 32'(bus_if.fifo_rd_en), 32'd0);
    end
    check("en_drop_drained", 32'(bus_if.m_valid), 32'd0);
    tick();
    en = 1'b1;
    repeat (50) tick();
    check("en_resume_all", 32'(exp_q.size()), 32'd0);

    // Reset while words are buffered and in flight
    for (int i = 0; i < 6; i++) load($urandom);
    repeat (4) tick();
    reset_dut(2);
    repeat (20) tick();
    check("rst_mid_drain", 32'(exp_q.size()), 32'd0);

    // Counter wrap with a 4-bit counter
    reset_dut(2);
    for (int i = 0; i < 17; i++) load(32'h1000 + 32'(i));
    repeat (25) tick();
    check("wrap_count", 32'(rd_count), 32'd1);
    check("wrap_delivered", 32'(delivered), 32'd17);

    // Randomised traffic
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) mode = $urandom_range(0, 2);
      en = ($urandom_range(0, 7) != 0);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = ($urandom_range(0, 3) == 0);
      endcase
      if ((fq.size() + stage_q.size()) < 4 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) load($urandom);
      end
      if (i == 700) reset_dut(2);
      tick();
    end
    en = 1'b1;
    m_ready = 1'b1;
    repeat (40) tick();
    check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
    check("rand_fifo_empty", 32'(fq.size()), 32'd0);
    check("rand_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Reader-side adapter for the team's synchronous FIFO. It drives the FIFO read port (cs, rd_en) and absorbs its one-cycle registered read latency. It presents the popped words as a valid/ready stream to a downstream consumer. A 2-entry output buffer sustains 1 word/cycle with full backpressure and no word loss.

Parameters:
DATA_WIDTH, 32, word width; must match the FIFO data_width.
CNT_WIDTH, 16, width of delivered-word counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
en  in  1  block enable; when low, no new FIFO reads are issued.
fifo_cs  out  1  FIFO chip select; equals en.
fifo_rd_en  out  1  FIFO read request; a pop occurs at the clk edge whenever it is high.
fifo_empty  in  1  FIFO empty flag.
fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
m_valid  out  1  output word valid.
m_ready  in  1  consumer ready.
m_data  out  DATA_WIDTH  output word.
rd_count  out  CNT_WIDTH  count of completed m_valid&&m_ready handshakes; wraps modulo 2^CNT_WIDTH.
busy  out  1  high when occ != 0 or inflight = 1.

Behaviour:
- Reset (rst=0, async): buffer cleared, occ=0, inflight=0, rd_count=0, m_data=0.
  - Outputs during reset: m_valid=0, fifo_rd_en=0, busy=0.
  - A word in flight at reset is discarded.
  - Reset release is synchronous to clk.
- FIFO contract: fifo_rd_en=1 with fifo_cs=1 and fifo_empty=0 in cycle N pops one word. fifo_dout carries that word in cycle N+1.
- State:
  - occ: 0/1/2, output-buffer occupancy; states EMPTY, ONE, TWO.
  - inflight: 1 bit, set the cycle after a pop.
  - 2-entry buffer, head/tail index.
- pop = m_valid && m_ready.
- fifo_rd_en = en && !fifo_empty && (occ + inflight - pop) < 2.
  - Gating by !fifo_empty guarantees every asserted rd_en is a real pop.
  - The combinational path m_ready -> fifo_rd_en is intentional; it is required for full throughput.
- inflight register: inflight <= fifo_rd_en each cycle.
- Capture: when inflight=1, fifo_dout is written to the buffer tail at the edge. The word is visible on m_data the next cycle.
- Latency: fifo_rd_en in cycle N -> m_valid in cycle N+2.
- Output: m_valid = (occ != 0); m_data = head entry.
  - m_data/m_valid are held stable while m_valid=1 and m_ready=0.
- Occupancy transitions (capture = inflight):
  - capture && !pop: occ+1.
  - pop && !capture: occ-1.
  - Both or neither: occ unchanged; a simultaneous capture and pop in TWO is legal.
  - Writes to a full buffer are unreachable by construction; an assertion flags occ>2.
- Throughput: with m_ready=1 and FIFO never empty, one word/cycle in steady state (occ=1, inflight=1).
- Backpressure: with m_ready held 0, at most 2 words leave the FIFO, then fifo_rd_en stays 0.
- en deasserted mid-stream: no new reads. The in-flight word is still captured, and buffered words still drain via m_ready.
- fifo_empty rising while inflight: the in-flight word is still captured; no further reads.
- rd_count increments on every pop; it wraps from all-ones to 0.

Decomposition:
- Shared package holds:
  - the occupancy state enum: OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2;
  - the default DATA_WIDTH.
- One natural sub-module: fifo_rd_skid, the 2-entry buffer with push/pop/occ. Top level holds the issue logic, inflight flag and counter.
- Expected total: roughly 150-250 lines.

Test Plan:
- Single word: FIFO holds 32'hA5A5_0001, m_ready=1, en=1 -> fifo_rd_en high cycle 0; m_valid=1 with m_data=32'hA5A5_0001 in cycle 2; rd_count=1; busy=0 after cycle 3.
- Streaming: FIFO preloaded with 8 words 0..7, m_ready=1 -> words 0..7 appear in order on consecutive cycles 2..9; fifo_rd_en high cycles 0..7; rd_count=8.
- Backpressure: 8 words preloaded, m_ready=0 for 10 cycles -> exactly 2 pops; m_data=0 held stable. Then m_ready=1 -> words 0..7 in order, no gaps after the first.
- Enable drop: stream running, en=0 for 5 cycles -> fifo_rd_en=0 immediately; in-flight plus buffered words (≤2) drain; m_valid then 0. en=1 resumes with the next word, no loss or duplication.
- Reset mid-operation: assert rst with occ=2 and inflight=1 -> m_valid=0, rd_count=0, busy=0 immediately (async). After release, no stale word emitted.
- Counter wrap: CNT_WIDTH=4, 17 handshakes -> rd_count reads 1.
